// File: rtl/skin_pkg.sv
// Shared defaults for the skin-mask statistics block: field widths, the
// default Cb/Cr skin window and the bounding-box record.
package skin_pkg;

    localparam int DEF_H_W   = 11;
    localparam int DEF_V_W   = 11;
    localparam int DEF_CNT_W = 21;

    localparam logic [7:0] CB_MIN = 8'd77;
    localparam logic [7:0] CB_MAX = 8'd127;
    localparam logic [7:0] CR_MIN = 8'd133;
    localparam logic [7:0] CR_MAX = 8'd173;

    // Wide enough for any supported H_W/V_W (<= 16); narrower coordinates are zero-extended.
    localparam int BBOX_FW = 16;

    typedef struct packed {
        logic [BBOX_FW-1:0] xmin;
        logic [BBOX_FW-1:0] xmax;
        logic [BBOX_FW-1:0] ymin;
        logic [BBOX_FW-1:0] ymax;
    } bbox_t;

endpackage

// File: rtl/delay.sv
// Generic N-bit wide, DELAY-deep clock-enabled delay line with synchronous reset.
module delay #(
    parameter int N     = 1,
    parameter int DELAY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    logic [DELAY-1:0][N-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // NOTE: this short shift register is reset (unlike a RAM) so the delayed syncs read inactive out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else if (ce) begin
            // NOTE: non-blocking so every stage samples the pre-edge value of its neighbour.
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/skin_classify.sv
// Cb/Cr window classifier: combinational stage-1 hit plus two registered
// stages so the mask lines up with the 2-cycle sync delay.
module skin_classify (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [7:0] cb,
    input  logic [7:0] cr,
    input  logic       de,
    input  logic [7:0] cb_min,
    input  logic [7:0] cb_max,
    input  logic [7:0] cr_min,
    input  logic [7:0] cr_max,
    output logic       hit,
    output logic       mask
);

    logic hit_d, hit_q;
    logic mask_d, mask_q;

    // An inverted window (min > max) can never satisfy both compares.
    always_comb begin
        // NOTE: every always_comb output gets a value first so no path infers a latch.
        hit_d  = de && (cb >= cb_min) && (cb <= cb_max) && (cr >= cr_min) && (cr <= cr_max);
        mask_d = hit_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= 1'b0;
            mask_q <= 1'b0;
        end else if (ce) begin
            hit_q  <= hit_d;
            mask_q <= mask_d;
        end
    end

    assign hit  = hit_d;
    assign mask = mask_q;

endmodule

// File: rtl/skin_mask_stats.sv
// Skin mask stream plus per-frame skin statistics published on each vsync edge.
// Optional bounding-box tracking is built only when SKIN_BBOX_EN is defined.
module skin_mask_stats
    import skin_pkg::*;
#(
    parameter int   H_W    = DEF_H_W,
    parameter int   V_W    = DEF_V_W,
    parameter int   CNT_W  = DEF_CNT_W,
    parameter logic VS_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [7:0]       Y,
    input  logic [7:0]       Cb,
    input  logic [7:0]       Cr,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_de,
    input  logic [7:0]       cb_min,
    input  logic [7:0]       cb_max,
    input  logic [7:0]       cr_min,
    input  logic [7:0]       cr_max,
    output logic             mask,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic             out_de,
    output logic [CNT_W-1:0] skin_count,
    output logic [H_W-1:0]   bbox_xmin,
    output logic [H_W-1:0]   bbox_xmax,
    output logic [V_W-1:0]   bbox_ymin,
    output logic [V_W-1:0]   bbox_ymax,
    output logic             bbox_empty,
    output logic             stats_valid
);

    logic unused_y;
    assign unused_y = ^Y;

    logic hit;

    skin_classify u_classify (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .cb     (Cb),
        .cr     (Cr),
        .de     (in_de),
        .cb_min (cb_min),
        .cb_max (cb_max),
        .cr_min (cr_min),
        .cr_max (cr_max),
        .hit    (hit),
        .mask   (mask)
    );

    delay #(.N(1), .DELAY(2)) u_dly_hs (.clk(clk), .rst(rst), .ce(ce), .din(in_hsync), .dout(out_hsync));
    delay #(.N(1), .DELAY(2)) u_dly_vs (.clk(clk), .rst(rst), .ce(ce), .din(in_vsync), .dout(out_vsync));
    delay #(.N(1), .DELAY(2)) u_dly_de (.clk(clk), .rst(rst), .ce(ce), .din(in_de),    .dout(out_de));

    logic [H_W-1:0]   x_q, x_d;
    logic [V_W-1:0]   y_q, y_d;
    logic             de_prev_q, de_prev_d;
    logic             vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [CNT_W-1:0] skin_count_q, skin_count_d;
    logic             bbox_empty_q, bbox_empty_d;
    logic             stats_valid_q, stats_valid_d;

    logic de_fall, frame_end;
    assign de_fall   = de_prev_q && !in_de;
    assign frame_end = (in_vsync == VS_POL) && (vs_prev_q != VS_POL);

`ifdef SKIN_BBOX_EN
    bbox_t              acc_q, acc_d, acc_base;
    logic [BBOX_FW-1:0] x_e, y_e;
    logic [H_W-1:0]     xmin_q, xmin_d, xmax_q, xmax_d;
    logic [V_W-1:0]     ymin_q, ymin_d, ymax_q, ymax_d;

    assign x_e = BBOX_FW'(x_q);
    assign y_e = BBOX_FW'(y_q);
`endif

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        de_prev_d     = in_de;
        vs_prev_d     = in_vsync;
        skin_count_d  = skin_count_q;
        bbox_empty_d  = bbox_empty_q;
        stats_valid_d = frame_end;
        // A hit in the frame-end cycle already belongs to the new frame.
        cnt_base      = frame_end ? '0 : cnt_q;
        cnt_d         = cnt_base;

        if (in_de) begin
            x_d = x_q + H_W'(1);
        end else if (de_fall) begin
            x_d = '0;
        end

        if (frame_end) begin
            y_d = '0;
        end else if (de_fall) begin
            y_d = y_q + V_W'(1);
        end

        if (frame_end) begin
            skin_count_d = cnt_q;
            bbox_empty_d = (cnt_q == '0);
        end

        if (hit && (cnt_base != '1)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end

`ifdef SKIN_BBOX_EN
        acc_base = frame_end ? '0 : acc_q;
        acc_d    = acc_base;
        xmin_d   = xmin_q;
        xmax_d   = xmax_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;

        if (frame_end) begin
            xmin_d = (cnt_q == '0) ? '0 : acc_q.xmin[H_W-1:0];
            xmax_d = (cnt_q == '0) ? '0 : acc_q.xmax[H_W-1:0];
            ymin_d = (cnt_q == '0) ? '0 : acc_q.ymin[V_W-1:0];
            ymax_d = (cnt_q == '0) ? '0 : acc_q.ymax[V_W-1:0];
        end

        // The accumulator contents are meaningless until the first hit of a frame.
        if (hit) begin
            if (cnt_base == '0) begin
                acc_d = '{xmin: x_e, xmax: x_e, ymin: y_e, ymax: y_e};
            end else begin
                if (x_e < acc_base.xmin) acc_d.xmin = x_e;
                if (x_e > acc_base.xmax) acc_d.xmax = x_e;
                if (y_e < acc_base.ymin) acc_d.ymin = y_e;
                if (y_e > acc_base.ymax) acc_d.ymax = y_e;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            de_prev_q     <= 1'b0;
            vs_prev_q     <= ~VS_POL;
            cnt_q         <= '0;
            skin_count_q  <= '0;
            bbox_empty_q  <= 1'b1;
            stats_valid_q <= 1'b0;
`ifdef SKIN_BBOX_EN
            acc_q         <= '0;
            xmin_q        <= '0;
            xmax_q        <= '0;
            ymin_q        <= '0;
            ymax_q        <= '0;
`endif
        end else if (ce) begin
            x_q           <= x_d;
            y_q           <= y_d;
            de_prev_q     <= de_prev_d;
            vs_prev_q     <= vs_prev_d;
            cnt_q         <= cnt_d;
            skin_count_q  <= skin_count_d;
            bbox_empty_q  <= bbox_empty_d;
            stats_valid_q <= stats_valid_d;
`ifdef SKIN_BBOX_EN
            acc_q         <= acc_d;
            xmin_q        <= xmin_d;
            xmax_q        <= xmax_d;
            ymin_q        <= ymin_d;
            ymax_q        <= ymax_d;
`endif
        end
    end

    assign skin_count  = skin_count_q;
    assign bbox_empty  = bbox_empty_q;
    // The pulse register holds through ce=0 cycles; gating keeps the strobe to a single enabled cycle.
    assign stats_valid = stats_valid_q && ce;

`ifdef SKIN_BBOX_EN
    assign bbox_xmin = xmin_q;
    assign bbox_xmax = xmax_q;
    assign bbox_ymin = ymin_q;
    assign bbox_ymax = ymax_q;
`else
    assign bbox_xmin = '0;
    assign bbox_xmax = '0;
    assign bbox_ymin = '0;
    assign bbox_ymax = '0;
`endif

endmodule

// File: tb/tb_skin_mask_stats.sv
// Scoreboard bench for skin_mask_stats: per-pixel mask/sync pipeline and
// per-frame statistics, with ce toggling and mid-frame reset.
module tb_skin_mask_stats;
    import skin_pkg::*;

`ifdef SKIN_BBOX_EN
    localparam bit BBOX_ON = 1'b1;
`else
    localparam bit BBOX_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ce;
    logic [7:0]  y_in, cb, cr;
    logic        hs, vs, de;
    logic [7:0]  cb_min, cb_max, cr_min, cr_max;
    logic        mask, out_hsync, out_vsync, out_de;
    logic [20:0] skin_count;
    logic [10:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic        bbox_empty, stats_valid;

    skin_mask_stats dut (
        .clk(clk), .rst(rst), .ce(ce),
        .Y(y_in), .Cb(cb), .Cr(cr),
        .in_hsync(hs), .in_vsync(vs), .in_de(de),
        .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
        .mask(mask), .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
        .skin_count(skin_count),
        .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
        .bbox_empty(bbox_empty), .stats_valid(stats_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic de, hs, vs, mask; } pix_t;
    typedef struct { int count, xmin, xmax, ymin, ymax; bit empty; } stat_t;

    pix_t  pipe_q[$];
    stat_t stat_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    toggle = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [7:0] c_b, input logic [7:0] c_r);
        return (c_b >= cb_min) && (c_b <= cb_max) && (c_r >= cr_min) && (c_r <= cr_max);
    endfunction

    function automatic stat_t mk_stat(input int c, input int x0, input int x1, input int y0, input int y1);
        stat_t s;
        s.count = c;
        s.empty = (c == 0);
        if (c == 0 || !BBOX_ON) begin
            s.xmin = 0; s.xmax = 0; s.ymin = 0; s.ymax = 0;
        end else begin
            s.xmin = x0; s.xmax = x1; s.ymin = y0; s.ymax = y1;
        end
        return s;
    endfunction

    function automatic bit is_skin(input int scen, input int x, input int y);
        case (scen)
            0:       return (x >= 2) && (x <= 5) && (y >= 1) && (y <= 2);
            2:       return (x == 7) && (y == 3);
            default: return 1'b0;
        endcase
    endfunction

    // Output seen in an enabled cycle belongs to the input two enabled cycles earlier.
    always @(negedge clk) begin
        if (!rst && ce && pipe_q.size() > 2) begin
            pix_t e;
            e = pipe_q.pop_front();
            check("out_de",    32'(out_de),    32'(e.de));
            check("out_hsync", 32'(out_hsync), 32'(e.hs));
            check("out_vsync", 32'(out_vsync), 32'(e.vs));
            check("mask",      32'(mask),      32'(e.mask));
        end
    end

    always @(negedge clk) begin
        if (!rst && stats_valid) begin
            check("stats_valid_ce", 32'(ce), 32'd1);
            if (stat_q.size() == 0) begin
                check("stats_valid_spurious", 32'd1, 32'd0);
            end else begin
                stat_t s;
                s = stat_q.pop_front();
                check("skin_count", 32'(skin_count), s.count);
                check("bbox_empty", 32'(bbox_empty), 32'(s.empty));
                check("bbox_xmin",  32'(bbox_xmin),  s.xmin);
                check("bbox_xmax",  32'(bbox_xmax),  s.xmax);
                check("bbox_ymin",  32'(bbox_ymin),  s.ymin);
                check("bbox_ymax",  32'(bbox_ymax),  s.ymax);
            end
        end
    end

    task automatic drive(input logic [7:0] c_b, input logic [7:0] c_r, input logic d, input logic h, input logic v);
        pix_t e;
        if (toggle) begin
            // Garbage while disabled must not disturb any state.
            ce = 1'b0;
            cb = 8'($urandom); cr = 8'($urandom); y_in = 8'($urandom);
            de = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
            @(posedge clk); #1;
        end
        ce = 1'b1;
        cb = c_b; cr = c_r; de = d; hs = h; vs = v; y_in = 8'($urandom);
        e.de = d; e.hs = h; e.vs = v; e.mask = d && in_win(c_b, c_r);
        pipe_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        pix_t z;
        rst = 1'b1;
        ce  = 1'b0;
        de = 1'b0; hs = 1'b0; vs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        pipe_q.delete();
        stat_q.delete();
        z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0; z.mask = 1'b0;
        pipe_q.push_back(z);
        pipe_q.push_back(z);
        check("rst_skin_count", 32'(skin_count), 32'd0);
        check("rst_bbox_empty", 32'(bbox_empty), 32'd1);
        check("rst_bbox_xmax",  32'(bbox_xmax),  32'd0);
        check("rst_bbox_ymax",  32'(bbox_ymax),  32'd0);
        check("rst_mask",       32'(mask),       32'd0);
        check("rst_out_de",     32'(out_de),     32'd0);
    endtask

    task automatic wait_stats();
        for (int i = 0; i < 20 && stat_q.size() != 0; i++) begin
            drive(8'd60, 8'd100, 1'b0, 1'b0, 1'b0);
        end
        check("stats_timeout", 32'(stat_q.size()), 32'd0);
    endtask

    task automatic end_frame(input stat_t s);
        stat_q.push_back(s);
        drive(8'd60, 8'd100, 1'b0, 1'b0, 1'b1);
        drive(8'd60, 8'd100, 1'b0, 1'b0, 1'b1);
        drive(8'd60, 8'd100, 1'b0, 1'b0, 1'b0);
        drive(8'd60, 8'd100, 1'b0, 1'b0, 1'b0);
        wait_stats();
    endtask

    task automatic run_frame(input int scen, input int rst_line, input stat_t s);
        for (int l = 0; l < 4; l++) begin
            for (int x = 0; x < 8; x++) begin
                if (is_skin(scen, x, l)) drive(8'd100, 8'd150, 1'b1, 1'b0, 1'b0);
                else                     drive(8'd60,  8'd100, 1'b1, 1'b0, 1'b0);
            end
            drive(8'd60, 8'd100, 1'b0, 1'b1, 1'b0);
            drive(8'd60, 8'd100, 1'b0, 1'b0, 1'b0);
            if (l == rst_line) do_reset();
        end
        end_frame(s);
    endtask

    initial begin
        logic [7:0] vcb [6];
        logic [7:0] vcr [6];
        vcb = '{8'd100, 8'd76, 8'd127, 8'd128, 8'd77, 8'd127};
        vcr = '{8'd150, 8'd150, 8'd173, 8'd150, 8'd133, 8'd174};

        rst = 1'b1; ce = 1'b0; y_in = 8'd0; cb = 8'd0; cr = 8'd0;
        hs = 1'b0; vs = 1'b0; de = 1'b0;
        cb_min = CB_MIN; cb_max = CB_MAX; cr_min = CR_MIN; cr_max = CR_MAX;
        do_reset();

        // Window edges on one line: hits at x=0,2,4.
        for (int i = 0; i < 6; i++) drive(vcb[i], vcr[i], 1'b1, 1'b0, 1'b0);
        drive(8'd60, 8'd100, 1'b0, 1'b1, 1'b0);
        drive(8'd60, 8'd100, 1'b0, 1'b0, 1'b0);
        end_frame(mk_stat(3, 0, 4, 0, 0));

        run_frame(0, -1, mk_stat(8, 2, 5, 1, 2));
        run_frame(1, -1, mk_stat(0, 0, 0, 0, 0));
        run_frame(2, -1, mk_stat(1, 7, 7, 3, 3));

        toggle = 1'b1;
        run_frame(0, -1, mk_stat(8, 2, 5, 1, 2));
        toggle = 1'b0;

        // Reset after line 1: only line 2 (now counted as y=0) remains.
        run_frame(0, 1, mk_stat(4, 2, 5, 0, 0));

        cb_min = 8'd200; cb_max = 8'd100;
        run_frame(0, -1, mk_stat(0, 0, 0, 0, 0));
        cb_min = CB_MIN; cb_max = CB_MAX;

        for (int i = 0; i < 4; i++) drive(8'd60, 8'd100, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
